// File: rtl/simd_add_stage.sv
// simd_add_stage: a SIMD add/subtract stage with 1x64/2x32/4x16/8x8 lane
// modes. The stage keeps a 2-entry output buffer under valid/ready flow
// control and counts the results that leave it.

// 8-bit ripple-carry slice of the datapath.
module simd_add_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic c;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

module simd_add_stage #(
    parameter int unsigned LANES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   a,
    input  logic [8*LANES-1:0]   b,
    input  logic [1:0]           lane_mode,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   sum,
    output logic [LANES-1:0]     cout,
    output logic [15:0]          ops_done
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                pop;
    int unsigned         span;
    logic [LANES-1:0]    boundary;
    logic [LANES-1:0]    lane_top;
    logic [8*LANES-1:0]  res_sum;
    logic [LANES-1:0]    res_cout;
    logic [8*LANES-1:0]  head_sum;
    logic [8*LANES-1:0]  tail_sum;
    logic [LANES-1:0]    head_cout;
    logic [LANES-1:0]    tail_cout;

    // Mark which slices start a lane and which slices end one for the current mode.
    always_comb begin
        span     = LANES >> lane_mode;
        boundary = '0;
        lane_top = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            boundary[k] = (k % span) == 0;
            lane_top[k] = ((k + 1) % span) == 0;
        end
    end

    // Carry chain: lane-start slices take sub as carry-in, others take the
    // previous slice's carry-out. B is inverted for subtraction.
    for (genvar k = 0; k < LANES; k++) begin : g_slice
        logic       ci;
        logic       co;
        logic [7:0] bs;

        assign bs = b[8*k +: 8] ^ {8{sub}};

        if (k == 0) begin : g_first
            assign ci = sub;
        end else begin : g_chain
            assign ci = boundary[k] ? sub : g_slice[k-1].co;
        end

        simd_add_adder8 u_add (
            .a    (a[8*k +: 8]),
            .b    (bs),
            .cin  (ci),
            .sum  (res_sum[8*k +: 8]),
            .cout (co)
        );

        assign res_cout[k] = lane_top[k] & co;
    end

    // Buffer occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // Handshake decode and occupancy next-state.
    always_comb begin
        state_next = state;
        in_ready   = (state != TWO);
        out_valid  = (state != EMPTY);
        accept     = in_valid && in_ready;
        pop        = out_valid && out_ready;
        case (state)
            EMPTY: if (accept) state_next = ONE;
            ONE: begin
                if (accept && !pop)      state_next = TWO;
                else if (pop && !accept) state_next = EMPTY;
            end
            TWO:   if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Entry storage: head is the oldest result, tail the younger one.
    // An accept concurrent with a pop in ONE writes straight into the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_sum  <= '0;
            head_cout <= '0;
            tail_sum  <= '0;
            tail_cout <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_sum  <= res_sum;
                        head_cout <= res_cout;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_sum  <= res_sum;
                        head_cout <= res_cout;
                    end else if (accept) begin
                        tail_sum  <= res_sum;
                        tail_cout <= res_cout;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_sum  <= tail_sum;
                        head_cout <= tail_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Count results taken by the downstream consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ops_done <= '0;
        else if (pop) ops_done <= ops_done + 16'd1;
    end

    assign sum  = head_sum;
    assign cout = head_cout;

endmodule

// File: tb/tb_simd_add_stage.sv
// Self-checking bench for simd_add_stage against a lane-arithmetic model
// and a FIFO scoreboard.
module tb_simd_add_stage;

    typedef logic [71:0] entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  lane_mode;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic [7:0]  cout;
    logic [15:0] ops_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    entry_t      q[$];
    logic [15:0] model_ops = '0;

    simd_add_stage #(.LANES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .lane_mode (lane_mode),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    // Lane-wise arithmetic: each lane is an independent lw-bit add or subtract.
    function automatic entry_t ref_op(input logic [63:0] av, input logic [63:0] bv,
                                      input logic [1:0] m, input logic s);
        int unsigned n;
        int unsigned lw;
        logic [64:0] mask;
        logic [64:0] la;
        logic [64:0] lb;
        logic [64:0] r;
        logic [63:0] rs;
        logic [7:0]  rc;
        logic        carry;
        n    = 1 << m;
        lw   = 64 / n;
        mask = (65'd1 << lw) - 65'd1;
        rs   = '0;
        rc   = '0;
        for (int unsigned l = 0; l < n; l++) begin
            la = ({1'b0, av} >> (l * lw)) & mask;
            lb = ({1'b0, bv} >> (l * lw)) & mask;
            if (s) begin
                r     = (la - lb) & mask;
                carry = (la >= lb);
            end else begin
                r     = la + lb;
                carry = r[lw];
                r     = r & mask;
            end
            rs = rs | 64'(r << (l * lw));
            rc[(l + 1) * lw / 8 - 1] = carry;
        end
        return {rc, rs};
    endfunction

    function automatic logic [63:0] rnd64();
        if ($urandom_range(0, 3) == 0) return '1;
        return {$urandom, $urandom};
    endfunction

    // Drive one cycle from a negedge to the next, updating the scoreboard.
    task automatic cyc(input logic v, input logic [63:0] av, input logic [63:0] bv,
                       input logic [1:0] m, input logic s, input logic ordy);
        bit acc;
        bit pp;
        in_valid  = v;
        a         = av;
        b         = bv;
        lane_mode = m;
        sub       = s;
        out_ready = ordy;
        acc = v && (q.size() < 2);
        pp  = ordy && (q.size() > 0);
        @(negedge clk);
        if (pp) begin
            void'(q.pop_front());
            model_ops = model_ops + 16'd1;
        end
        if (acc) q.push_back(ref_op(av, bv, m, s));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        model_ops = '0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_tests++; if (sum !== 64'd0) begin n_fail++; $display("FAIL reset_sum got %h exp 0", sum); end
        n_tests++; if (cout !== 8'd0) begin n_fail++; $display("FAIL reset_cout got %h exp 0", cout); end
        n_tests++; if (ops_done !== 16'd0) begin n_fail++; $display("FAIL reset_ops_done got %h exp 0", ops_done); end
        in_valid = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid got %b exp 0", out_valid); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        q.delete();
        model_ops = '0;
    endtask

    task automatic test_directed();
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL d64_valid got %b exp 1", out_valid); end
        n_tests++; if (sum !== 64'd0) begin n_fail++; $display("FAIL d64_sum got %h exp 0", sum); end
        n_tests++; if (cout !== 8'h80) begin n_fail++; $display("FAIL d64_cout got %h exp 80", cout); end
        cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL d64_drain got %b exp 0", out_valid); end

        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 2'b11, 1'b0, 1'b0);
        n_tests++; if (sum !== 64'd0) begin n_fail++; $display("FAIL d8_sum got %h exp 0", sum); end
        n_tests++; if (cout !== 8'hFF) begin n_fail++; $display("FAIL d8_cout got %h exp ff", cout); end
        cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);

        cyc(1'b1, 64'h0000_0005_0000_0003, 64'h0000_0003_0000_0005, 2'b01, 1'b1, 1'b0);
        n_tests++; if (sum !== 64'h0000_0002_FFFF_FFFE) begin n_fail++; $display("FAIL d32sub_sum got %h exp 00000002fffffffe", sum); end
        n_tests++; if (cout !== 8'h80) begin n_fail++; $display("FAIL d32sub_cout got %h exp 80", cout); end
        n_tests++; if ({cout, sum} !== q[0]) begin n_fail++; $display("FAIL d32sub_model got %h exp %h", {cout, sum}, q[0]); end
        cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
        n_tests++; if (ops_done !== 16'd3) begin n_fail++; $display("FAIL d_ops got %0d exp 3", ops_done); end
    endtask

    task automatic test_backpressure();
        logic [63:0] wa[3];
        logic [63:0] wb[3];
        logic [1:0]  wm[3];
        logic        ws[3];
        entry_t      e[3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wa[i] = rnd64();
            wb[i] = rnd64();
            wm[i] = 2'($urandom_range(0, 3));
            ws[i] = 1'($urandom_range(0, 1));
            e[i]  = ref_op(wa[i], wb[i], wm[i], ws[i]);
        end
        cyc(1'b1, wa[0], wb[0], wm[0], ws[0], 1'b0);
        n_tests++; if ({out_valid, in_ready, cout, sum} !== {2'b11, e[0]}) begin n_fail++; $display("FAIL bp_first got %h exp %h", {out_valid, in_ready, cout, sum}, {2'b11, e[0]}); end
        cyc(1'b1, wa[1], wb[1], wm[1], ws[1], 1'b0);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
        cyc(1'b1, wa[2], wb[2], wm[2], ws[2], 1'b0);
        n_tests++; if ({out_valid, in_ready, cout, sum} !== {2'b10, e[0]}) begin n_fail++; $display("FAIL bp_stall got %h exp %h", {out_valid, in_ready, cout, sum}, {2'b10, e[0]}); end
        cyc(1'b1, wa[2], wb[2], wm[2], ws[2], 1'b1);
        n_tests++; if ({out_valid, in_ready, cout, sum} !== {2'b11, e[1]}) begin n_fail++; $display("FAIL bp_pop1 got %h exp %h", {out_valid, in_ready, cout, sum}, {2'b11, e[1]}); end
        cyc(1'b1, wa[2], wb[2], wm[2], ws[2], 1'b1);
        n_tests++; if ({out_valid, in_ready, cout, sum} !== {2'b11, e[2]}) begin n_fail++; $display("FAIL bp_pop2 got %h exp %h", {out_valid, in_ready, cout, sum}, {2'b11, e[2]}); end
        cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
        n_tests++; if ({out_valid, ops_done} !== {1'b0, 16'd3}) begin n_fail++; $display("FAIL bp_done got %h exp 00003", {out_valid, ops_done}); end
    endtask

    task automatic test_stream();
        do_reset();
        cyc(1'b1, rnd64(), rnd64(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, rnd64(), rnd64(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            n_tests++;
            if ({out_valid, in_ready, cout, sum} !== {2'b11, q[0]}) begin
                n_fail++;
                $display("FAIL stream_%0d got %h exp %h", i, {out_valid, in_ready, cout, sum}, {2'b11, q[0]});
            end
        end
        n_tests++; if (ops_done !== 16'd100) begin n_fail++; $display("FAIL stream_ops got %0d exp 100", ops_done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), rnd64(), rnd64(), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
            n_tests++;
            if ({out_valid, in_ready, ops_done} !== {q.size() != 0, q.size() < 2, model_ops}) begin
                n_fail++;
                $display("FAIL rand_ctl_%0d got %h exp %h", i, {out_valid, in_ready, ops_done},
                         {q.size() != 0, q.size() < 2, model_ops});
            end
            if (q.size() > 0) begin
                n_tests++;
                if ({cout, sum} !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data_%0d got %h exp %h", i, {cout, sum}, q[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1'b1, rnd64(), rnd64(), 2'b00, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
        cyc(1'b1, rnd64(), rnd64(), 2'b01, 1'b0, 1'b0);
        cyc(1'b1, rnd64(), rnd64(), 2'b10, 1'b1, 1'b0);
        n_tests++; if ({in_ready, ops_done} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL rmid_pre got %h exp 00001", {in_ready, ops_done}); end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if ({out_valid, in_ready, ops_done} !== {2'b01, 16'd0}) begin n_fail++; $display("FAIL rmid_async got %h exp %h", {out_valid, in_ready, ops_done}, {2'b01, 16'd0}); end
        n_tests++; if ({cout, sum} !== 72'd0) begin n_fail++; $display("FAIL rmid_data got %h exp 0", {cout, sum}); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        model_ops = '0;
        cyc(1'b1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001, 2'b10, 1'b0, 1'b0);
        n_tests++; if ({out_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL rmid_first_ctl got %b exp 11", {out_valid, in_ready}); end
        n_tests++; if (sum !== 64'h8000_8000_8000_8000) begin n_fail++; $display("FAIL rmid_sum got %h exp 8000800080008000", sum); end
        n_tests++; if (cout !== 8'h00) begin n_fail++; $display("FAIL rmid_cout got %h exp 00", cout); end
        cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
        n_tests++; if ({out_valid, ops_done} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL rmid_pop got %h exp 00001", {out_valid, ops_done}); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        lane_mode = 2'b00;
        sub       = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_stream();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
